tf_gen_ctrl: RTL and testbench
==============================

# tf_gen_ctrl

Sequencing controller that drives the twiddle-factor generator's control side and hands generated twiddle factors to the butterfly datapath. On `start` it loads the base bank, then builds each iteration depth with a read, multiply-wait, write-back cycle. It then streams depths 0..IT_DEPTH to the consumer over a valid/ready handshake. It sits between the NWC top-level FSM and `TF_gen`. The twiddle data itself flows from `TF_gen` to the consumer; this block carries only control and beat indices.

## Interface
Parameters:
- D_WIDTH, `` `D_width ``, width of depth/idx/phase buses
- IT_DEPTH, 3, highest iteration depth generated (0 allowed)
- MUL_LAT, 4, barrett_reduction pipeline latency in cycles (≥1)
- RD_LAT, 1, register-bank read latency in cycles (≥1)

Ports:
- clk  in  1  clock; single clock domain, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a generate+stream run; sampled only in IDLE
- TF_ren  out  1  register-bank read enable
- TF_wen  out  1  register-bank write enable
- it_depth_cnt  out  D_WIDTH  depth addressed by current read/write
- l  out  D_WIDTH  phase code: 0 idle, 1 load, 2 generate, 3 stream
- idx_base  out  D_WIDTH  bank index base, equals current stream beat number
- tf_valid  out  1  twiddle set for depth `tf_depth` is present at TF_gen outputs
- tf_ready  in  1  consumer accepts the current set
- tf_depth  out  D_WIDTH  depth of the set offered with tf_valid
- busy  out  1  high from first cycle after accepted start through DONE
- done  out  1  single-cycle pulse in DONE

## Operation
- States: IDLE, LOAD, GEN_RD, GEN_WAIT, GEN_WR, STR_SETTLE, STR_VALID, DONE.
- IDLE: all outputs 0. start=1 → LOAD. start in any other state is ignored.
- LOAD, 1 cycle: TF_wen=1, it_depth_cnt=0, l=1. → GEN_RD with d=1. If IT_DEPTH=0, → STR_SETTLE instead.
- GEN_RD, 1 cycle: TF_ren=1, it_depth_cnt=d-1, l=2.
- GEN_WAIT, MUL_LAT cycles: TF_ren=TF_wen=0, it_depth_cnt=d, l=2.
- GEN_WR, 1 cycle: TF_wen=1, it_depth_cnt=d. Then d==IT_DEPTH → STR_SETTLE with k=0; otherwise d+1 → GEN_RD.
- STR_SETTLE, RD_LAT cycles: TF_ren=1, it_depth_cnt=k, idx_base=k, l=3, tf_valid=0.
- STR_VALID: same drive as STR_SETTLE plus tf_valid=1 and tf_depth=k.
  - Hold while tf_ready=0.
  - On tf_valid&&tf_ready: k==IT_DEPTH → DONE; otherwise k+1 → STR_SETTLE.
- DONE, 1 cycle: done=1, busy=1, TF_ren=TF_wen=0. → IDLE.
- TF_ren and TF_wen are never high in the same cycle.
- Counters d, k and the wait counter are D_WIDTH wide and never wrap, since IT_DEPTH < 2^D_WIDTH.

## Timing
- Reset: rst sampled high → next state IDLE. All outputs, d, k and the wait counter are 0. This holds from any state, including mid-GEN_WAIT or mid-stall. No partial write is issued after reset.
- Call the cycle with start=1 in IDLE cycle 0. LOAD is cycle 1. Generation occupies cycles 2 .. 1+IT_DEPTH·(MUL_LAT+2).
- Stream entry k with tf_ready held high: STR_SETTLE k lasts RD_LAT cycles, then STR_VALID k lasts 1 cycle.
- Defaults: STREAM starts at cycle 20. Valid beats fall on cycles 21, 23, 25, 27. DONE is cycle 28. IDLE is cycle 29, and a new start is accepted in cycle 29.
- tf_depth, idx_base and it_depth_cnt stay stable while tf_valid=1 and tf_ready=0.
- All outputs are registered, with zero combinational path from tf_ready or start.

## Structure
- Package `tf_ctrl_pkg`: state enum `tf_ctrl_state_e`, phase constants PH_IDLE=0, PH_LOAD=1, PH_GEN=2, PH_STR=3.
- Sub-module `tf_lat_cnt`: loadable down-counter with a `zero` flag. It is reused for both MUL_LAT and RD_LAT waits.
- Top: FSM, d/k counters, registered output decode.
- Expected size is about 200 lines of RTL.

## Test plan
- Reset, then start=1 for 1 cycle with tf_ready=1 and defaults: TF_wen at cycle 1 with depth 0; TF_ren at cycles 2, 8, 14; TF_wen at cycles 7, 13, 19 with depths 1, 2, 3; tf_valid at cycles 21, 23, 25, 27 with tf_depth 0..3; done at cycle 28.
- tf_ready=0 for cycles 21–24, then 1: tf_valid stays high with tf_depth=0 and it_depth_cnt=0 through cycle 24, is accepted in cycle 25, and done moves from cycle 28 to cycle 32.
- IT_DEPTH=0: LOAD at cycle 1, STR_SETTLE at cycle 2, tf_valid with tf_depth=0 at cycle 3, done at cycle 4, and no TF_ren during any GEN_RD.
- rst asserted in cycle 10 (GEN_WAIT, d=2): from cycle 11 all outputs are 0 and the FSM is in IDLE; a later start replays the full default trace exactly.
- start pulses in cycles 5 and 28 are ignored; start in cycle 29 begins a new run, with LOAD at cycle 30.
- Assertion over all tests: TF_ren&&TF_wen never occurs, and done is never high for two consecutive cycles.

Source files
------------

// File: rtl/tf_ctrl_pkg.sv
// tf_ctrl_pkg: shared state encoding and phase codes for the twiddle-factor sequencing controller
package tf_ctrl_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GEN_RD,
        ST_GEN_WAIT,
        ST_GEN_WR,
        ST_STR_SETTLE,
        ST_STR_VALID,
        ST_DONE
    } tf_ctrl_state_e;
    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_GEN = 2;
    localparam int PH_STR = 3;
    localparam int D_WIDTH_DEF = 8;
endpackage

// File: rtl/tf_lat_cnt.sv
// tf_lat_cnt: loadable down-counter with a zero flag, used for multiplier and bank-read waits
module tf_lat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt_q, cnt_d;
    assign zero = cnt_q == '0;
    always_comb cnt_d = load ? load_val : zero ? cnt_q : cnt_q - W'(1);
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/tf_gen_ctrl.sv
// tf_gen_ctrl: sequences twiddle-factor bank load/generate/stream and offers each depth over valid/ready
module tf_gen_ctrl
    import tf_ctrl_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int IT_DEPTH = 3,
    parameter int MUL_LAT = 4,
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               TF_ren,
    output logic               TF_wen,
    output logic [D_WIDTH-1:0] it_depth_cnt,
    output logic [D_WIDTH-1:0] l,
    output logic [D_WIDTH-1:0] idx_base,
    output logic               tf_valid,
    input  logic               tf_ready,
    output logic [D_WIDTH-1:0] tf_depth,
    output logic               busy,
    output logic               done
);
    localparam logic [D_WIDTH-1:0] LAST = D_WIDTH'(IT_DEPTH);
    tf_ctrl_state_e state_q, state_d;
    logic [D_WIDTH-1:0] d_q, d_d, k_q, k_d, depth_d, l_d, lat_val;
    logic lat_zero, lat_load, is_gen, is_str;
    tf_lat_cnt #(.W(D_WIDTH)) u_lat (
        .clk(clk),
        .rst(rst),
        .load(lat_load),
        .load_val(lat_val),
        .zero(lat_zero)
    );
    always_comb begin
        state_d = state_q;
        d_d = d_q;
        k_d = k_q;
        case (state_q)
            ST_IDLE: state_d = start ? ST_LOAD : ST_IDLE;
            ST_LOAD: begin
                state_d = IT_DEPTH == 0 ? ST_STR_SETTLE : ST_GEN_RD;
                d_d = D_WIDTH'(1);
                k_d = '0;
            end
            ST_GEN_RD: state_d = ST_GEN_WAIT;
            ST_GEN_WAIT: state_d = lat_zero ? ST_GEN_WR : ST_GEN_WAIT;
            ST_GEN_WR: begin
                state_d = d_q == LAST ? ST_STR_SETTLE : ST_GEN_RD;
                d_d = d_q == LAST ? d_q : d_q + D_WIDTH'(1);
                k_d = '0;
            end
            ST_STR_SETTLE: state_d = lat_zero ? ST_STR_VALID : ST_STR_SETTLE;
            ST_STR_VALID: begin
                state_d = !tf_ready ? ST_STR_VALID : k_q == LAST ? ST_DONE : ST_STR_SETTLE;
                k_d = tf_ready && k_q != LAST ? k_q + D_WIDTH'(1) : k_q;
            end
            ST_DONE: state_d = ST_IDLE;
        endcase
    end
    // Outputs are decoded from the next state and registered, so they line up with state_q.
    always_comb begin
        is_gen = state_d inside {ST_GEN_RD, ST_GEN_WAIT, ST_GEN_WR};
        is_str = state_d inside {ST_STR_SETTLE, ST_STR_VALID};
        depth_d = state_d == ST_GEN_RD ? d_d - D_WIDTH'(1) : is_gen ? d_d : is_str ? k_d : '0;
        l_d = state_d == ST_LOAD ? D_WIDTH'(PH_LOAD) : is_gen ? D_WIDTH'(PH_GEN) :
              is_str ? D_WIDTH'(PH_STR) : D_WIDTH'(PH_IDLE);
        lat_load = state_d != state_q;
        lat_val = state_d == ST_GEN_WAIT ? D_WIDTH'(MUL_LAT - 1) : D_WIDTH'(RD_LAT - 1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            d_q <= '0;
            k_q <= '0;
            TF_ren <= 1'b0;
            TF_wen <= 1'b0;
            it_depth_cnt <= '0;
            l <= '0;
            idx_base <= '0;
            tf_valid <= 1'b0;
            tf_depth <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q <= d_d;
            k_q <= k_d;
            TF_ren <= is_str || state_d == ST_GEN_RD;
            TF_wen <= state_d inside {ST_LOAD, ST_GEN_WR};
            it_depth_cnt <= depth_d;
            l <= l_d;
            idx_base <= is_str ? k_d : '0;
            tf_valid <= state_d == ST_STR_VALID;
            tf_depth <= state_d == ST_STR_VALID ? k_d : '0;
            busy <= state_d != ST_IDLE;
            done <= state_d == ST_DONE;
        end
    end
endmodule

// File: tb/tb_tf_gen_ctrl.sv
// tb_tf_gen_ctrl: cycle-exact trace check of tf_gen_ctrl against a phase-schedule reference model
module tb_tf_gen_ctrl;
    typedef struct packed {
        logic ren;
        logic wen;
        logic [7:0] depth;
        logic [7:0] l;
        logic [7:0] idx;
        logic valid;
        logic [7:0] tdepth;
        logic busy;
        logic done;
    } out_t;
    localparam int MUL = 4;
    localparam int RDL = 1;
    logic clk = 0, rst = 1, start = 0, start0 = 0, tf_ready = 1;
    logic ren_a, wen_a, val_a, busy_a, done_a, ren_b, wen_b, val_b, busy_b, done_b;
    logic [7:0] dep_a, l_a, idx_a, td_a, dep_b, l_b, idx_b, td_b;
    out_t obs_a, obs_b;
    int checks = 0, failures = 0;
    logic rdy[0:511];
    out_t exp_q[0:511];
    int len, pc, done_cyc;
    bit pd_a, pd_b;

    tf_gen_ctrl #(.D_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .TF_ren(ren_a), .TF_wen(wen_a),
        .it_depth_cnt(dep_a), .l(l_a), .idx_base(idx_a), .tf_valid(val_a),
        .tf_ready(tf_ready), .tf_depth(td_a), .busy(busy_a), .done(done_a)
    );
    tf_gen_ctrl #(.D_WIDTH(8), .IT_DEPTH(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .TF_ren(ren_b), .TF_wen(wen_b),
        .it_depth_cnt(dep_b), .l(l_b), .idx_base(idx_b), .tf_valid(val_b),
        .tf_ready(tf_ready), .tf_depth(td_b), .busy(busy_b), .done(done_b)
    );
    assign obs_a = {ren_a, wen_a, dep_a, l_a, idx_a, val_a, td_a, busy_a, done_a};
    assign obs_b = {ren_b, wen_b, dep_b, l_b, idx_b, val_b, td_b, busy_b, done_b};

    always #5 clk = ~clk;

    always @(negedge clk) begin
        checks += 2;
        if ((ren_a === 1'b1 && wen_a === 1'b1) || (ren_b === 1'b1 && wen_b === 1'b1)) begin
            failures++;
            $display("FAIL ren_wen_overlap got=1 exp=0 at %0t", $time);
        end
        if ((done_a === 1'b1 && pd_a) || (done_b === 1'b1 && pd_b)) begin
            failures++;
            $display("FAIL done_double got=two-cycle exp=single at %0t", $time);
        end
        pd_a = done_a === 1'b1;
        pd_b = done_b === 1'b1;
    end

    function automatic out_t mk(bit ren, bit wen, int depth, int ph, int idx, bit valid,
                                int tdepth, bit bsy, bit dn);
        mk = {ren, wen, 8'(depth), 8'(ph), 8'(idx), valid, 8'(tdepth), bsy, dn};
    endfunction

    task automatic put(input out_t v);
        exp_q[pc] = v;
        pc++;
    endtask

    // Expected per-cycle outputs, cycle 0 being the start cycle; stream stalls follow rdy[].
    task automatic build_model(input int n);
        bit acc;
        for (int i = 0; i < 512; i++) exp_q[i] = '0;
        pc = 1;
        put(mk(0, 1, 0, 1, 0, 0, 0, 1, 0));
        for (int d = 1; d <= n; d++) begin
            put(mk(1, 0, d - 1, 2, 0, 0, 0, 1, 0));
            repeat (MUL) put(mk(0, 0, d, 2, 0, 0, 0, 1, 0));
            put(mk(0, 1, d, 2, 0, 0, 0, 1, 0));
        end
        for (int k = 0; k <= n; k++) begin
            repeat (RDL) put(mk(1, 0, k, 3, k, 0, 0, 1, 0));
            acc = 0;
            while (!acc && pc < 500) begin
                acc = rdy[pc] === 1'b1;
                put(mk(1, 0, k, 3, k, 1, k, 1, 0));
            end
        end
        put(mk(0, 0, 0, 0, 0, 0, 0, 1, 1));
        exp_q[pc] = '0;
        len = pc;
    endtask

    task automatic set_rdy_all(input bit v);
        for (int i = 0; i < 512; i++) rdy[i] = v;
    endtask

    task automatic run(input bit use0, input string name, input int rst_at, input int s1, input int s2);
        out_t got;
        done_cyc = -1;
        start = !use0;
        start0 = use0;
        tf_ready = rdy[0];
        for (int c = 1; c <= len; c++) begin
            @(posedge clk);
            #1;
            start = !use0 && (c == s1 || c == s2);
            start0 = 0;
            tf_ready = rdy[c];
            got = use0 ? obs_b : obs_a;
            checks++;
            if (got !== exp_q[c]) begin
                failures++;
                $display("FAIL %s cycle %0d got=%h exp=%h", name, c, got, exp_q[c]);
            end
            if (got.done === 1'b1 && done_cyc < 0) done_cyc = c;
            if (c == rst_at) begin
                rst = 1;
                break;
            end
        end
    endtask

    task automatic check_done_at(input string name, input int want);
        checks++;
        if (done_cyc != want) begin
            failures++;
            $display("FAIL %s done_cycle got=%0d exp=%0d", name, done_cyc, want);
        end
    endtask

    task automatic check_zero(input string name);
        checks += 2;
        if (obs_a !== '0) begin
            failures++;
            $display("FAIL %s dut got=%h exp=0", name, obs_a);
        end
        if (obs_b !== '0) begin
            failures++;
            $display("FAIL %s dut0 got=%h exp=0", name, obs_b);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 0;
        @(posedge clk);
        #1;
        check_zero("idle_after_reset");
    endtask

    task automatic test_default();
        set_rdy_all(1);
        build_model(3);
        run(0, "default", -1, -1, -1);
        check_done_at("default", 28);
    endtask

    task automatic test_back_to_back();
        set_rdy_all(1);
        build_model(3);
        run(0, "ignored_starts", -1, 5, 28);
        check_done_at("ignored_starts", 28);
        run(0, "restart_at_29", -1, -1, -1);
        check_done_at("restart_at_29", 28);
    endtask

    task automatic test_stall();
        set_rdy_all(1);
        for (int c = 21; c <= 24; c++) rdy[c] = 0;
        build_model(3);
        run(0, "stall", -1, -1, -1);
        check_done_at("stall", 32);
    endtask

    task automatic test_depth0();
        set_rdy_all(1);
        build_model(0);
        run(1, "depth0", -1, -1, -1);
        check_done_at("depth0", 4);
    endtask

    task automatic test_mid_reset();
        set_rdy_all(1);
        build_model(3);
        run(0, "mid_reset_pre", 10, -1, -1);
        @(posedge clk);
        #1;
        check_zero("mid_reset_c11");
        rst = 0;
        @(posedge clk);
        #1;
        check_zero("mid_reset_c12");
        run(0, "mid_reset_replay", -1, -1, -1);
        check_done_at("mid_reset_replay", 28);
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 512; c++) rdy[c] = c < 150 ? 1'($urandom_range(0, 1)) : 1'b1;
            build_model(r == 4 ? 0 : 3);
            run(r == 4, $sformatf("random%0d", r), -1, -1, -1);
            check_done_at($sformatf("random%0d", r), len - 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_rdy_all(1);
        test_reset();
        test_default();
        test_back_to_back();
        test_stall();
        test_depth0();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
